mtr_drv_ph: RTL and testbench
=============================

// Module: mtr_drv_ph
// PURPOSE
//  Parametrised N-phase motor bridge driver for the eBike drivetrain: free-running PWM, duty slew limiting,
//  per-phase commutation select, per-phase dead-time insertion and a latched over-current shutdown.
//  Sits between the commutation/torque control logic (duty, sel) and the bridge gate outputs.
// PARAMETERS
//  PWM_W      11  PWM counter/duty width; period = 2**PWM_W clocks
//  NUM_PH     3   number of half-bridge phases
//  DEADTIME   32  non-overlap cycles inserted on every desired-output change (>=1)
//  SLEW_STEP  16  max duty change per PWM period; 0 = no limiting (duty taken immediately at period start)
// PORTS
//  clk            in   1            system clock
//  rst_n          in   1            asynchronous active-low reset
//  duty           in   PWM_W        target duty (unsigned)
//  sel            in   2*NUM_PH     phase select, phase p = sel[2p+1:2p]
//  fault          in   1            over-current, active high, already synchronous to clk
//  clr_fault      in   1            request fault clear (level or pulse)
//  PWM_synch      out  1            high the single cycle cnt==0 (first cycle of each period)
//  high           out  NUM_PH       high-side gate drives
//  low            out  NUM_PH       low-side gate drives
//  fault_latched  out  1            fault shutdown active
//  duty_cur       out  PWM_W        duty currently applied (post-slew)
// BEHAVIOUR
//  Reset (async): cnt=0, duty_cur=0, high=low=0, fault_latched=0; dead-time counters loaded so
//   high/low stay 0 for the first DEADTIME edges after rst_n rises. Mid-operation reset: outputs 0 at once.
//  Counter: cnt PWM_W bits, +1 every clk, wraps 2**PWM_W-1 -> 0. PWM_sig = (cnt < duty_cur).
//   duty_cur=0 -> PWM_sig always 0; duty_cur=2**PWM_W-1 -> low only at cnt==max.
//  Slew: on the edge where cnt==max (wrap), duty_cur moves toward duty by min(SLEW_STEP,|duty-duty_cur|);
//   SLEW_STEP=0 -> duty_cur<=duty. duty_cur changes only at wrap; new value valid when PWM_synch=1.
//  Desired pair per phase (dh,dl) from sel: 00 coast (0,0); 01 (~PWM_sig,PWM_sig);
//   10 (PWM_sig,~PWM_sig); 11 brake (0,PWM_sig).
//  Dead time per phase: desired pair registered each edge. If pair sampled at edge k differs from edge k-1:
//   high=low=0 after edge k through edge k+DEADTIME-1; from edge k+DEADTIME outputs = desired.
//   Any further change during the window restarts it. Unchanged pair -> outputs = desired, 1 cycle latency.
//   high[p]&low[p] is never 1 in any cycle, under any stimulus.
//  Fault FSM: RUN -> FAULT when fault=1 at an edge; after that edge all high/low=0, fault_latched=1, duty_cur=0.
//   FAULT: outputs held 0, duty_cur held 0, cnt and PWM_synch keep running.
//   FAULT -> RUN on edge with clr_fault=1 and fault=0; fault=1 with clr_fault=1 stays FAULT (fault wins).
//   On exit: all dead-time windows restart (outputs 0 for DEADTIME more edges); duty_cur ramps from 0 per slew.
//  Arithmetic: slew add/sub computed PWM_W+1 wide, result clamped to [0, 2**PWM_W-1]; no wrap.
// TESTING (defaults unless stated)
//  Reset: drive sel=10,duty=1000, pulse rst_n low mid-period -> high/low/duty_cur/fault_latched 0 same cycle;
//   after release outputs 0 for 32 cycles, PWM_synch every 2048 cycles.
//  SLEW_STEP=0, sel phase0=10, duty=512 -> per period high[0]=1 for 480 cycles, low[0]=1 for 1504,
//   32-cycle all-off gaps at each transition, never both 1; phases 1,2 (sel=00) stay 0.
//  Slew: duty 0->100 -> duty_cur at successive PWM_synch = 16,32,48,64,80,96,100; then duty=0 -> 84,68,...,4,0.
//  Fault: duty=1000 steady, 1-cycle fault -> next edge all outputs 0, fault_latched=1, duty_cur=0;
//   clr_fault with fault=1 ignored; clr_fault with fault=0 -> fault_latched=0, outputs 0 32 more cycles, duty ramps 16,32,...
//  Modes: sel 10->01 mid high pulse -> both 0 for exactly 32 cycles then swapped polarity; sel=11 -> high=0, low follows
//   PWM_sig with dead time; sel=00 -> both 0 after 32-cycle window.
//  Boundaries: duty=0 sel=10 -> high never 1, low constant 1; duty=2047 -> low never 1 (pulses < DEADTIME absorbed).

Source files
------------

// File: rtl/mtr_drv_ph_if.sv
// Control-side bundle of the N-phase bridge driver: duty/select/fault requests in,
// gate drives and status out.
interface mtr_drv_ph_if #(
    parameter int unsigned PWM_W  = 11,
    parameter int unsigned NUM_PH = 3
);
    logic [PWM_W-1:0]    duty;
    logic [2*NUM_PH-1:0] sel;
    logic                fault;
    logic                clr_fault;
    logic                PWM_synch;
    logic [NUM_PH-1:0]   high;
    logic [NUM_PH-1:0]   low;
    logic                fault_latched;
    logic [PWM_W-1:0]    duty_cur;

    modport master (
        output duty, sel, fault, clr_fault,
        input  PWM_synch, high, low, fault_latched, duty_cur
    );

    modport slave (
        input  duty, sel, fault, clr_fault,
        output PWM_synch, high, low, fault_latched, duty_cur
    );
endinterface

// File: rtl/mtr_drv_ph.sv
// N-phase half-bridge driver: free-running PWM, slew-limited duty, per-phase commutation
// select with dead-time insertion, and a latched over-current shutdown.
module mtr_drv_ph #(
    parameter int unsigned PWM_W     = 11,
    parameter int unsigned NUM_PH    = 3,
    parameter int unsigned DEADTIME  = 32,
    parameter int unsigned SLEW_STEP = 16
) (
    input logic         clk,
    input logic         rst_n,
    mtr_drv_ph_if.slave bus
);
    localparam int unsigned EXT_W = PWM_W + 1;
    localparam int unsigned DT_W  = $clog2(DEADTIME + 1);
    localparam logic [PWM_W-1:0] CNT_MAX = '1;

    typedef enum logic {S_RUN = 1'b0, S_FAULT = 1'b1} state_t;

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic [PWM_W-1:0]             r_cnt;
    logic                         r_synch;
    logic [PWM_W-1:0]             r_duty_cur;
    logic [NUM_PH-1:0]            r_high;
    logic [NUM_PH-1:0]            r_low;
    logic                         r_fault_latched;
    logic [NUM_PH-1:0][1:0]       r_des;
    logic [NUM_PH-1:0][DT_W-1:0]  r_dt;

    logic                         w_hold;
    logic                         w_wrap;
    logic                         w_pwm;
    logic [EXT_W-1:0]             w_cur_x;
    logic [EXT_W-1:0]             w_tgt_x;
    logic [EXT_W-1:0]             w_step_x;
    logic [EXT_W-1:0]             w_diff_x;
    logic [EXT_W-1:0]             w_slew_x;
    logic [PWM_W-1:0]             w_slew;
    logic [PWM_W-1:0]             w_duty_nxt;
    logic [NUM_PH-1:0][1:0]       w_des;
    logic [NUM_PH-1:0][DT_W-1:0]  w_dt_nxt;
    logic [NUM_PH-1:0]            w_high_nxt;
    logic [NUM_PH-1:0]            w_low_nxt;

    assign w_wrap = (r_cnt == CNT_MAX);
    assign w_pwm  = (r_cnt < r_duty_cur);

    // Fault FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_RUN;
        else        r_state <= w_state_nxt;
    end

    // Fault FSM next state; fault wins over a simultaneous clear
    always_comb begin
        w_state_nxt = r_state;
        w_hold      = 1'b0;
        case (r_state)
            S_RUN: begin
                if (bus.fault) begin
                    w_state_nxt = S_FAULT;
                    w_hold      = 1'b1;
                end
            end
            S_FAULT: begin
                w_hold = 1'b1;
                if (bus.clr_fault && !bus.fault) w_state_nxt = S_RUN;
            end
            default: w_state_nxt = S_RUN;
        endcase
    end

    // Slew limiter, computed one bit wider so steps never wrap
    always_comb begin
        w_cur_x  = {1'b0, r_duty_cur};
        w_tgt_x  = {1'b0, bus.duty};
        w_step_x = EXT_W'(SLEW_STEP);
        w_diff_x = '0;
        w_slew_x = w_tgt_x;
        if (SLEW_STEP != 0) begin
            if (w_tgt_x > w_cur_x) begin
                w_diff_x = w_tgt_x - w_cur_x;
                if (w_diff_x > w_step_x) w_slew_x = w_cur_x + w_step_x;
            end else begin
                w_diff_x = w_cur_x - w_tgt_x;
                if (w_diff_x > w_step_x) w_slew_x = w_cur_x - w_step_x;
            end
        end
        w_slew = (w_slew_x > {1'b0, CNT_MAX}) ? CNT_MAX : w_slew_x[PWM_W-1:0];
    end

    assign w_duty_nxt = w_hold ? '0 : (w_wrap ? w_slew : r_duty_cur);

    // Desired (high, low) pair per phase from the commutation select
    always_comb begin
        w_des = '0;
        for (int p = 0; p < NUM_PH; p++) begin
            case (bus.sel[2*p +: 2])
                2'b01:   w_des[p] = {~w_pwm, w_pwm};
                2'b10:   w_des[p] = {w_pwm, ~w_pwm};
                2'b11:   w_des[p] = {1'b0, w_pwm};
                default: w_des[p] = 2'b00;
            endcase
        end
    end

    // Dead-time windows: any change of the desired pair, or a fault, forces both gates off
    always_comb begin
        w_dt_nxt   = r_dt;
        w_high_nxt = '0;
        w_low_nxt  = '0;
        for (int p = 0; p < NUM_PH; p++) begin
            if (w_hold) begin
                w_dt_nxt[p] = DT_W'(DEADTIME);
            end else if (w_des[p] != r_des[p]) begin
                w_dt_nxt[p] = DT_W'(DEADTIME - 1);
            end else if (r_dt[p] != '0) begin
                w_dt_nxt[p] = r_dt[p] - DT_W'(1);
            end else begin
                w_high_nxt[p] = w_des[p][1];
                w_low_nxt[p]  = w_des[p][0];
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt           <= '0;
            r_synch         <= 1'b1;
            r_duty_cur      <= '0;
            r_high          <= '0;
            r_low           <= '0;
            r_fault_latched <= 1'b0;
            r_des           <= '0;
            r_dt            <= {NUM_PH{DT_W'(DEADTIME)}};
        end else begin
            r_cnt           <= r_cnt + PWM_W'(1);
            r_synch         <= w_wrap;
            r_duty_cur      <= w_duty_nxt;
            r_high          <= w_high_nxt;
            r_low           <= w_low_nxt;
            r_fault_latched <= (w_state_nxt == S_FAULT);
            r_des           <= w_des;
            r_dt            <= w_dt_nxt;
        end
    end

    assign bus.PWM_synch     = r_synch;
    assign bus.high          = r_high;
    assign bus.low           = r_low;
    assign bus.fault_latched = r_fault_latched;
    assign bus.duty_cur      = r_duty_cur;
endmodule

// File: tb/tb_mtr_drv_ph.sv
// Directed bench for mtr_drv_ph: one slew-limited instance and one unlimited (SLEW_STEP=0)
// instance sharing clock and reset.
module tb_mtr_drv_ph;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mtr_drv_ph_if #(.PWM_W(11), .NUM_PH(3)) bus  ();
    mtr_drv_ph_if #(.PWM_W(11), .NUM_PH(3)) bus0 ();

    mtr_drv_ph #(.PWM_W(11), .NUM_PH(3), .DEADTIME(32), .SLEW_STEP(16)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    mtr_drv_ph #(.PWM_W(11), .NUM_PH(3), .DEADTIME(32), .SLEW_STEP(0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Advance until the chosen instance shows PWM_synch; gives up after 2100 edges
    task automatic wait_synch(input bit which, output int waited);
        waited = 0;
        do begin
            tick(1);
            waited++;
        end while (((which ? bus0.PWM_synch : bus.PWM_synch) !== 1'b1) && (waited < 2100));
    endtask

    // Per-cycle statistics of the unlimited instance over n edges
    task automatic count_win(input int n, output int nh0, output int nl0,
                             output int nboth, output int nother, output int nzero);
        nh0 = 0; nl0 = 0; nboth = 0; nother = 0; nzero = 0;
        for (int i = 0; i < n; i++) begin
            tick(1);
            if (bus0.high[0] === 1'b1) nh0++;
            if (bus0.low[0] === 1'b1) nl0++;
            if ((bus0.high & bus0.low) !== 3'b000) nboth++;
            if ((bus0.high[2:1] | bus0.low[2:1]) !== 2'b00) nother++;
            if (bus0.high[0] === 1'b0 && bus0.low[0] === 1'b0) nzero++;
        end
    endtask

    initial begin
        int w;
        int nh0, nl0, nboth, nother, nzero;
        int exp_up [7];
        int exp_dn [7];
        exp_up = '{16, 32, 48, 64, 80, 96, 100};
        exp_dn = '{84, 68, 52, 36, 20, 4, 0};
        n_checks = 0;
        n_errors = 0;

        rst_n          = 1'b0;
        bus.duty       = 11'd1000;
        bus.sel        = 6'b000010;
        bus.fault      = 1'b0;
        bus.clr_fault  = 1'b0;
        bus0.duty      = 11'd512;
        bus0.sel       = 6'b000010;
        bus0.fault     = 1'b0;
        bus0.clr_fault = 1'b0;
        #12;
        chk("rst_hl", 32'({bus.high, bus.low}), 32'd0);
        chk("rst_duty_cur", 32'(bus.duty_cur), 32'd0);
        chk("rst_fault_latched", 32'(bus.fault_latched), 32'd0);
        chk("rst_synch", 32'(bus.PWM_synch), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Startup dead time, then low side on (duty_cur still 0)
        for (int k = 1; k <= 32; k++) begin
            tick(1);
            chk("startup_dead", 32'({bus.high, bus.low}), 32'd0);
        end
        tick(1);
        chk("startup_low", 32'(bus.low), 32'd1);
        chk("startup_high", 32'(bus.high), 32'd0);
        wait_synch(1'b0, w);
        chk("first_synch_gap", 32'(w), 32'd2015);
        chk("first_duty_cur", 32'(bus.duty_cur), 32'd16);
        chk("nolim_duty_cur", 32'(bus0.duty_cur), 32'd512);
        tick(1);
        chk("synch_single", 32'(bus.PWM_synch), 32'd0);
        tick(151);
        chk("pre_rst_low", 32'(bus.low), 32'd1);

        // Mid-period reset clears outputs immediately
        rst_n = 1'b0;
        #1;
        chk("midrst_hl", 32'({bus.high, bus.low}), 32'd0);
        chk("midrst_duty_cur", 32'(bus.duty_cur), 32'd0);
        chk("midrst_fault_latched", 32'(bus.fault_latched), 32'd0);
        chk("midrst_nolim_hl", 32'({bus0.high, bus0.low}), 32'd0);
        bus.duty = 11'd100;
        @(negedge clk);
        rst_n = 1'b1;

        // Slew up 0 -> 100
        for (int i = 0; i < 7; i++) begin
            wait_synch(1'b0, w);
            chk("slew_up_gap", 32'(w), 32'd2048);
            chk("slew_up", 32'(bus.duty_cur), 32'(exp_up[i]));
        end

        // Steady 512/2048 on the unlimited instance
        count_win(2048, nh0, nl0, nboth, nother, nzero);
        chk("d512_high_cycles", 32'(nh0), 32'd480);
        chk("d512_low_cycles", 32'(nl0), 32'd1504);
        chk("d512_deadtime_cycles", 32'(nzero), 32'd64);
        chk("d512_overlap", 32'(nboth), 32'd0);
        chk("d512_coast_phases", 32'(nother), 32'd0);
        chk("slew_hold", 32'(bus.duty_cur), 32'd100);

        // Slew down 100 -> 0
        bus.duty = 11'd0;
        for (int i = 0; i < 7; i++) begin
            wait_synch(1'b0, w);
            chk("slew_dn_gap", 32'(w), 32'd2048);
            chk("slew_dn", 32'(bus.duty_cur), 32'(exp_dn[i]));
        end

        // Fault latch and clear
        bus.duty = 11'd1000;
        wait_synch(1'b0, w);
        chk("pre_fault_duty1", 32'(bus.duty_cur), 32'd16);
        wait_synch(1'b0, w);
        chk("pre_fault_duty2", 32'(bus.duty_cur), 32'd32);
        tick(100);
        chk("pre_fault_low", 32'(bus.low), 32'd1);
        bus.fault = 1'b1;
        tick(1);
        bus.fault = 1'b0;
        chk("fault_hl", 32'({bus.high, bus.low}), 32'd0);
        chk("fault_latched", 32'(bus.fault_latched), 32'd1);
        chk("fault_duty_cur", 32'(bus.duty_cur), 32'd0);
        tick(5);
        chk("fault_held", 32'(bus.fault_latched), 32'd1);
        bus.fault     = 1'b1;
        bus.clr_fault = 1'b1;
        tick(1);
        chk("clr_ignored", 32'(bus.fault_latched), 32'd1);
        chk("clr_ignored_hl", 32'({bus.high, bus.low}), 32'd0);
        bus.fault = 1'b0;
        tick(1);
        bus.clr_fault = 1'b0;
        chk("clr_latched", 32'(bus.fault_latched), 32'd0);
        chk("clr_hl", 32'({bus.high, bus.low}), 32'd0);
        for (int k = 1; k <= 32; k++) begin
            tick(1);
            chk("clr_dead", 32'({bus.high, bus.low}), 32'd0);
        end
        tick(1);
        chk("clr_low_on", 32'(bus.low), 32'd1);
        wait_synch(1'b0, w);
        chk("clr_synch_gap", 32'(w), 32'd1907);
        chk("clr_ramp1", 32'(bus.duty_cur), 32'd16);
        wait_synch(1'b0, w);
        chk("clr_ramp2", 32'(bus.duty_cur), 32'd32);

        // Mode change 10 -> 01 inside the high pulse
        tick(200);
        chk("mode_pre_high", 32'(bus0.high), 32'd1);
        chk("mode_pre_low", 32'(bus0.low), 32'd0);
        bus0.sel = 6'b000001;
        for (int k = 1; k <= 32; k++) begin
            tick(1);
            chk("mode_dead", 32'({bus0.high, bus0.low}), 32'd0);
        end
        tick(1);
        chk("mode_swap_low", 32'(bus0.low), 32'd1);
        chk("mode_swap_high", 32'(bus0.high), 32'd0);

        // Brake: low follows PWM with dead time, high off
        bus0.sel = 6'b000011;
        tick(2100);
        count_win(2048, nh0, nl0, nboth, nother, nzero);
        chk("brake_high", 32'(nh0), 32'd0);
        chk("brake_low", 32'(nl0), 32'd480);
        chk("brake_others", 32'(nother), 32'd0);

        // Coast
        bus0.sel = 6'b000000;
        tick(32);
        count_win(2048, nh0, nl0, nboth, nother, nzero);
        chk("coast_high", 32'(nh0), 32'd0);
        chk("coast_low", 32'(nl0), 32'd0);

        // Duty boundaries
        bus0.sel  = 6'b000010;
        bus0.duty = 11'd0;
        wait_synch(1'b1, w);
        chk("d0_duty_cur", 32'(bus0.duty_cur), 32'd0);
        tick(40);
        count_win(2048, nh0, nl0, nboth, nother, nzero);
        chk("d0_high", 32'(nh0), 32'd0);
        chk("d0_low", 32'(nl0), 32'd2048);
        bus0.duty = 11'd2047;
        wait_synch(1'b1, w);
        chk("dmax_duty_cur", 32'(bus0.duty_cur), 32'd2047);
        tick(40);
        count_win(2048, nh0, nl0, nboth, nother, nzero);
        chk("dmax_low", 32'(nl0), 32'd0);
        chk("dmax_high", 32'(nh0), 32'd2015);
        chk("dmax_overlap", 32'(nboth), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
